// File: rtl/z480_wb_arb.sv
// Writeback arbiter: round-robin merge of N_SRC execution-unit result channels
// into one registered writeback port toward the ROB/PRF.
package z480_pkg;
    typedef struct packed {
        logic [6:0]  rob_idx;
        logic [6:0]  dst_preg;
        logic        exc;
        logic [63:0] value;
    } z480_wb_t;
endpackage

module z480_wb_arb
    import z480_pkg::*;
#(
    parameter  int N_SRC = 4,
    localparam int RR_W  = $clog2(N_SRC)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic     [N_SRC-1:0]        src_valid,
    input  z480_wb_t [N_SRC-1:0]        src_wb,
    output logic     [N_SRC-1:0]        src_ready,
    output logic                        out_valid,
    output z480_wb_t                    out_wb,
    input  logic                        out_ready,
    output logic     [RR_W-1:0]         out_src
);

    logic             out_vld_p1;
    z480_wb_t         out_wb_p1;
    logic [RR_W-1:0]  out_src_p1;
    logic [RR_W-1:0]  rr_q;

    logic             slot_free;
    logic [N_SRC-1:0] grant;
    logic [RR_W-1:0]  gidx;
    logic [RR_W-1:0]  rr_next;
    logic             accept;
    int               idx;

    assign slot_free = !out_vld_p1 || out_ready;

    // Scan offsets from farthest to nearest so the last hit is the one closest to rr_q.
    always_comb begin
        grant = '0;
        gidx  = '0;
        idx   = 0;
        if (slot_free && !flush && rst_n) begin
            for (int k = N_SRC - 1; k >= 0; k--) begin
                idx = int'(rr_q) + k;
                if (idx >= N_SRC) idx = idx - N_SRC;
                if (src_valid[idx]) begin
                    grant      = '0;
                    grant[idx] = 1'b1;
                    gidx       = RR_W'(idx);
                end
            end
        end
    end

    assign src_ready = grant;
    assign accept    = |grant;
    assign rr_next   = (gidx == RR_W'(N_SRC - 1)) ? '0 : gidx + RR_W'(1);

    // Stage p1: registered writeback slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_p1 <= 1'b0;
            out_wb_p1  <= '0;
            out_src_p1 <= '0;
            rr_q       <= '0;
        end else if (flush) begin
            out_vld_p1 <= 1'b0;
        end else if (accept) begin
            out_vld_p1 <= 1'b1;
            out_wb_p1  <= src_wb[gidx];
            out_src_p1 <= gidx;
            rr_q       <= rr_next;
        end else if (out_ready) begin
            out_vld_p1 <= 1'b0;
        end
    end

    assign out_valid = out_vld_p1;
    assign out_wb    = out_wb_p1;
    assign out_src   = out_src_p1;

    a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(src_ready));
    a_wb_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_vld_p1 && !out_ready) |=> $stable(out_wb_p1));
    a_no_grant_on_flush: assert property (@(posedge clk) disable iff (!rst_n)
        flush |-> (src_ready == '0));

endmodule

// File: tb/tb_z480_wb_arb.sv
// Directed bench for z480_wb_arb: stimulus pushes expected records into a
// scoreboard queue, a negedge monitor pops and compares on every retirement.
module tb_z480_wb_arb;
    import z480_pkg::*;

    localparam int N = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               flush = 1'b0;
    logic               out_ready = 1'b1;
    logic     [N-1:0]   src_valid = '0;
    z480_wb_t [N-1:0]   src_wb = '0;
    logic     [N-1:0]   src_ready;
    logic               out_valid;
    z480_wb_t           out_wb;
    logic     [1:0]     out_src;

    int n_chk = 0;
    int n_err = 0;

    typedef struct packed {
        z480_wb_t   wb;
        logic [1:0] src;
    } exp_t;

    exp_t     sb[$];
    z480_wb_t cur[N];

    always #5 clk = ~clk;

    z480_wb_arb #(.N_SRC(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .src_valid (src_valid),
        .src_wb    (src_wb),
        .src_ready (src_ready),
        .out_valid (out_valid),
        .out_wb    (out_wb),
        .out_ready (out_ready),
        .out_src   (out_src)
    );

    function automatic z480_wb_t mk(input logic [6:0] r, input logic [63:0] v);
        z480_wb_t w;
        w.rob_idx  = r;
        w.dst_preg = r ^ 7'h2a;
        w.exc      = r[0];
        w.value    = v;
        return w;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_src;
        for (int i = 0; i < N; i++) src_wb[i] = cur[i];
    endtask

    task automatic push(input logic [1:0] s);
        exp_t e;
        e.wb  = cur[s];
        e.src = s;
        sb.push_back(e);
    endtask

    // Monitor: scoreboard pop on retirement, plus hold checks across backpressure.
    initial begin
        logic               have_prev;
        logic               prev_bp;
        logic               prev_flush;
        z480_wb_t           prev_wb;
        logic [1:0]         prev_src;
        logic [N-1:0]       prev_sv;
        z480_wb_t [N-1:0]   prev_swb;
        exp_t               e;
        have_prev = 1'b0;
        prev_bp = 1'b0;
        prev_flush = 1'b0;
        prev_wb = '0;
        prev_src = '0;
        prev_sv = '0;
        prev_swb = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have_prev = 1'b0;
            end else begin
                if (have_prev && prev_bp) begin
                    chk("bp_out_wb_stable", out_wb, prev_wb);
                    chk("bp_out_src_stable", out_src, prev_src);
                    if (!prev_flush) begin
                        chk("bp_out_valid_held", out_valid, 1);
                        chk("bp_src_valid_stable", src_valid, prev_sv);
                        n_chk++;
                        if (src_wb !== prev_swb) begin
                            n_err++;
                            $display("FAIL bp_src_wb_stable: got %0h expected %0h", src_wb, prev_swb);
                        end
                    end
                end
                if (out_valid && out_ready && !flush) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL sb_unexpected: got rob_idx %0h src %0d expected no record",
                                 out_wb.rob_idx, out_src);
                    end else begin
                        e = sb.pop_front();
                        chk("sb_out_wb", out_wb, e.wb);
                        chk("sb_out_src", out_src, e.src);
                    end
                end
                have_prev  = 1'b1;
                prev_bp    = out_valid && !out_ready;
                prev_flush = flush;
                prev_wb    = out_wb;
                prev_src   = out_src;
                prev_sv    = src_valid;
                prev_swb   = src_wb;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] g;
        for (int i = 0; i < N; i++) cur[i] = '0;
        src_valid = '1;

        // Reset state, with all sources requesting
        #1 rst_n = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_wb", out_wb, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_rr", dut.rr_q, 0);
        tick;
        rst_n = 1'b1;

        // All four valid continuously: grants 0,1,2,3,0
        for (int i = 0; i < N; i++) cur[i] = mk(7'(16 + i), 64'(i) * 64'h1000);
        drive_src();
        src_valid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            g = 2'(c % 4);
            @(negedge clk);
            chk("rr_grant", src_ready, 4'b0001 << g);
            if (c > 0) chk("rr_out_valid", out_valid, 1);
            push(g);
            tick;
            cur[g] = mk(cur[g].rob_idx + 7'd4, cur[g].value + 64'd1);
            drive_src();
        end
        src_valid = '0;
        @(negedge clk);
        chk("rr_after_seq", dut.rr_q, 1);
        chk("idle_ready", src_ready, 0);
        tick;
        @(negedge clk);
        chk("drained_valid", out_valid, 0);
        tick;

        // Single source 2
        cur[2] = mk(7'd5, 64'hDEAD);
        drive_src();
        src_valid = 4'b0100;
        @(negedge clk);
        chk("single_ready", src_ready, 4'b0100);
        push(2'd2);
        tick;
        src_valid = '0;
        @(negedge clk);
        chk("single_rr", dut.rr_q, 3);
        chk("single_out_valid", out_valid, 1);
        chk("single_rob_idx", out_wb.rob_idx, 5);
        chk("single_value", out_wb.value, 64'hDEAD);
        chk("single_out_src", out_src, 2);
        chk("single_ready_after", src_ready, 0);
        tick;

        // Wrap from rr_q=3
        cur[3] = mk(7'd30, 64'h3030);
        cur[0] = mk(7'd31, 64'h3131);
        drive_src();
        src_valid = 4'b1001;
        @(negedge clk);
        chk("wrap_grant3", src_ready, 4'b1000);
        push(2'd3);
        tick;
        src_valid = 4'b0001;
        @(negedge clk);
        chk("wrap_rr0", dut.rr_q, 0);
        chk("wrap_grant0", src_ready, 4'b0001);
        push(2'd0);
        tick;
        src_valid = '0;
        @(negedge clk);
        chk("wrap_rr1", dut.rr_q, 1);
        tick;

        // Backpressure with rob_idx=7 held for 3 cycles
        out_ready = 1'b0;
        cur[0] = mk(7'd7, 64'h7777);
        drive_src();
        src_valid = 4'b0001;
        @(negedge clk);
        chk("bp_fill_grant", src_ready, 4'b0001);
        push(2'd0);
        tick;
        cur[1] = mk(7'd8, 64'h8888);
        drive_src();
        src_valid = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_ready_low", src_ready, 0);
            chk("bp_rob_idx", out_wb.rob_idx, 7);
            chk("bp_valid", out_valid, 1);
            tick;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_grant", src_ready, 4'b0010);
        push(2'd1);
        tick;
        src_valid = '0;
        @(negedge clk);
        chk("bp_no_bubble", out_valid, 1);
        chk("bp_next_rob", out_wb.rob_idx, 8);
        tick;

        // Flush while holding a record under backpressure
        out_ready = 1'b0;
        cur[2] = mk(7'd9, 64'h9999);
        drive_src();
        src_valid = 4'b0100;
        @(negedge clk);
        chk("fl_fill_grant", src_ready, 4'b0100);
        tick;
        cur[0] = mk(7'd10, 64'hA0A0);
        drive_src();
        src_valid = 4'b0001;
        flush = 1'b1;
        @(negedge clk);
        chk("fl_ready_low", src_ready, 0);
        chk("fl_rr", dut.rr_q, 3);
        tick;
        flush = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("fl_out_valid", out_valid, 0);
        chk("fl_rr_kept", dut.rr_q, 3);
        chk("fl_post_grant", src_ready, 4'b0001);
        push(2'd0);
        tick;
        src_valid = '0;
        @(negedge clk);
        chk("fl_rr_after", dut.rr_q, 1);
        tick;

        // Asynchronous reset mid-backpressure
        out_ready = 1'b0;
        cur[1] = mk(7'd11, 64'hB0B0);
        drive_src();
        src_valid = 4'b0010;
        @(negedge clk);
        chk("ar_fill_grant", src_ready, 4'b0010);
        tick;
        cur[1] = mk(7'd13, 64'hD0D0);
        cur[2] = mk(7'd12, 64'hC0C0);
        drive_src();
        src_valid = 4'b0110;
        @(negedge clk);
        chk("ar_bp_ready", src_ready, 0);
        chk("ar_bp_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_src_ready", src_ready, 0);
        chk("ar_rr", dut.rr_q, 0);
        chk("ar_out_wb", out_wb, 0);
        tick;
        tick;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("ar_first_grant", src_ready, 4'b0010);
        push(2'd1);
        tick;
        src_valid = 4'b0100;
        @(negedge clk);
        chk("ar_second_grant", src_ready, 4'b0100);
        push(2'd2);
        tick;
        src_valid = '0;
        @(negedge clk);
        tick;
        @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
